wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NREQ, default 3, SHALL give the number of write-back requesters (0=ALU, 1=LSU, 2=CSR).
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  NREQ  per-requester write-back request.
REQ-005 req_rd  input  NREQ*5  per-requester destination register index.
REQ-006 req_data  input  NREQ*32  per-requester write data.
REQ-007 req_ready  output  NREQ  one-hot grant; the handshake completes when valid and ready are both high.
REQ-008 alloc_valid  input  1  issue stage reserves a destination register.
REQ-009 alloc_rd  input  5  register being reserved.
REQ-010 wr_valid  output  1  register-file write strobe (drives data_valid).
REQ-011 wr_rd  output  5  register-file write index.
REQ-012 wr_data  output  32  register-file write data.
REQ-013 busy  output  32  scoreboard; bit i high means x_i has a pending write.

Function
REQ-014 Arbitration SHALL be round-robin: the search starts at index last_grant+1 modulo NREQ and grants the first valid requester.
REQ-015 At most one req_ready bit SHALL be high per cycle.
REQ-016 req_ready SHALL be combinational from req_valid and the pointer, and SHALL be low for any requester with req_valid low.
REQ-017 last_grant SHALL update only on a completed handshake; with no request it SHALL hold.
REQ-018 The write port SHALL be registered with latency 1: a grant in cycle N gives wr_valid=1, wr_rd and wr_data in cycle N+1.
REQ-019 When no handshake occurs, wr_valid SHALL be 0 in the next cycle; wr_rd and wr_data SHALL hold their previous values.
REQ-020 A request with rd=0 SHALL be granted and consumed normally, but SHALL produce wr_valid=0.
REQ-021 Throughput SHALL be one write per cycle with no bubbles while any request is pending.
REQ-022 On alloc_valid with alloc_rd!=0, busy[alloc_rd] SHALL be set at the next edge.
REQ-023 A granted write to rd SHALL clear busy[rd] at the same edge that loads wr_*.
REQ-024 If a set and a clear target the same register in the same cycle, the set SHALL win.
REQ-025 busy[0] SHALL be constant 0.
REQ-026 A grant to a register that is not busy SHALL be permitted and SHALL leave busy unchanged.
REQ-027 alloc_valid SHALL be independent of arbitration; both SHALL proceed in the same cycle.

Reset
REQ-028 While rst=0 at a rising edge, the block SHALL set wr_valid=0, wr_rd=0, wr_data=0, busy=0 and last_grant=NREQ-1, so requester 0 has first priority.
REQ-029 During reset, req_ready SHALL be all-zero and no handshake SHALL complete.
REQ-030 A request in flight at reset SHALL be dropped; the requester must re-present it after reset.

Structure
REQ-031 NREQ default, requester index constants (REQ_ALU, REQ_LSU, REQ_CSR) and the register-index width (5) SHALL live in the shared CPU package.
REQ-032 The round-robin grant logic SHALL be a sub-module rr_arbiter (request vector and pointer in, one-hot grant out).
REQ-033 The scoreboard SHALL be inline in wb_arbiter.

Verification
REQ-034 Reset release, no requests -> wr_valid=0, busy=0, req_ready=000 for all cycles.
REQ-035 Requesters 0, 1 and 2 all valid and held for 6 cycles (rd 1/2/3, data 0x11/0x22/0x33) -> grants 0,1,2,0,1,2; wr_rd sequence 1,2,3,1,2,3, each one cycle after its grant.
REQ-036 alloc x5, then 2 cycles later requester 1 writes rd=5 data 0xDEADBEEF -> busy[5]=1 until the grant edge, then 0; wr_valid=1, wr_rd=5, wr_data=0xDEADBEEF in the following cycle.
REQ-037 alloc x7 in the same cycle as a grant to rd=7 -> busy[7]=1 afterwards; wr_rd=7 is written.
REQ-038 Requester 2 writes rd=0 data 0xFFFFFFFF; alloc rd=0 -> handshake completes, wr_valid stays 0, busy[0]=0.
REQ-039 rst=0 asserted while requesters 0 and 1 are valid and busy=0x000000F0 -> next cycle busy=0, wr_valid=0; after release, requester 0 is granted first.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared CPU package for the write-back stage.
// Holds the default requester count, the requester index constants,
// the register-index and data widths, and a helper that sizes the
// round-robin pointer so that a single requester still gets a 1-bit field.
package wb_arbiter_pkg;

  localparam int NREQ_DEFAULT = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_CSR = 2;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 1 << REG_IDX_W;
  localparam int DATA_W    = 32;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin grant logic.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index of the requester granted most recently
//   grant - one-hot grant; zero when no request is present
// The search starts one past ptr and wraps, so the last winner has the
// lowest priority on the next arbitration.
module rr_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N     = NREQ_DEFAULT,
  parameter int PTR_W = ptr_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  int   idx;
  logic found;

  // Walk the requesters in rotated order and keep only the first hit.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back arbiter with register scoreboard.
// Ports:
//   clk, rst     - clock and synchronous active-low reset
//   req_valid    - per-requester write-back request (0=ALU, 1=LSU, 2=CSR)
//   req_rd       - per-requester destination index, packed 5 bits each
//   req_data     - per-requester write data, packed 32 bits each
//   req_ready    - one-hot grant back to the requesters
//   alloc_valid  - issue stage reserves alloc_rd as a pending destination
//   alloc_rd     - register being reserved
//   wr_valid     - register-file write strobe, one cycle after the grant
//   wr_rd        - register-file write index
//   wr_data      - register-file write data
//   busy         - scoreboard, bit i set while x_i has a pending write
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*5-1:0]      req_rd,
  input  logic [NREQ*32-1:0]     req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   alloc_valid,
  input  logic [4:0]             alloc_rd,
  output logic                   wr_valid,
  output logic [4:0]             wr_rd,
  output logic [31:0]            wr_data,
  output logic [31:0]            busy
);

  localparam int PTR_W = ptr_width(NREQ);

  logic [PTR_W-1:0]     last_grant;
  logic [NREQ-1:0]      grant;
  logic                 handshake;
  logic [PTR_W-1:0]     grant_idx;
  logic [REG_IDX_W-1:0] grant_rd;
  logic [DATA_W-1:0]    grant_data;
  logic [NUM_REGS-1:0]  busy_next;

  rr_arbiter #(
    .N     (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req   (req_valid),
    .ptr   (last_grant),
    .grant (grant)
  );

  // Masking with rst keeps any handshake from completing while in reset.
  assign req_ready = rst ? grant : '0;
  assign handshake = |(req_valid & req_ready);

  // Select the winning requester's payload; req_ready is one-hot so at
  // most one iteration matches.
  always_comb begin
    grant_idx  = '0;
    grant_rd   = '0;
    grant_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        grant_idx  = PTR_W'(i);
        grant_rd   = req_rd[i*REG_IDX_W +: REG_IDX_W];
        grant_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Scoreboard update: clear on write-back, then set on allocation so a
  // same-cycle set to the same register wins. x0 never reads as busy.
  always_comb begin
    busy_next = busy;
    if (handshake) begin
      busy_next[grant_rd] = 1'b0;
    end
    if (alloc_valid) begin
      busy_next[alloc_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Pointer moves only on a completed handshake; reset parks it on the
  // last requester so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= PTR_W'(NREQ - 1);
    end else if (handshake) begin
      last_grant <= grant_idx;
    end
  end

  // Registered write port. A grant to x0 is consumed but never strobes
  // the register file; index and data hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_valid <= 1'b0;
      wr_rd    <= '0;
      wr_data  <= '0;
    end else if (handshake) begin
      wr_valid <= (grant_rd != '0);
      wr_rd    <= grant_rd;
      wr_data  <= grant_data;
    end else begin
      wr_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: self-checking bench for wb_arbiter (3 requesters).
// A behavioural model tracks the round-robin pointer, the scoreboard and
// the expected write port; directed scenarios are followed by random traffic.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        wr_valid;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_last;
  logic [31:0] m_busy;
  logic        m_wr_valid;
  logic [4:0]  m_wr_rd;
  logic [31:0] m_wr_data;

  wb_arbiter #(.NREQ(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .wr_valid    (wr_valid),
    .wr_rd       (wr_rd),
    .wr_data     (wr_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] v,
                               input logic [4:0] rd0, input logic [4:0] rd1,
                               input logic [4:0] rd2, input logic [31:0] d0,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic av, input logic [4:0] ard);
    rst         = r;
    req_valid   = v;
    req_rd      = {rd2, rd1, rd0};
    req_data    = {d2, d1, d0};
    alloc_valid = av;
    alloc_rd    = ard;
  endtask

  // Round-robin rule: search from last+1 modulo 3, first valid wins.
  function automatic int model_grant(input int last, input logic [2:0] v);
    for (int k = 1; k <= 3; k++) begin
      if (v[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  // One clock: check the grant, advance the model, step, check outputs.
  task automatic runCycle();
    int          g;
    logic [2:0]  exp_ready;
    logic [4:0]  grd;
    #1;
    g = model_grant(m_last, req_valid);
    exp_ready = (rst && g >= 0) ? 3'(1 << g) : 3'b000;
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    if (!rst) begin
      m_last = 2; m_busy = '0;
      m_wr_valid = 1'b0; m_wr_rd = '0; m_wr_data = '0;
    end else begin
      if (g >= 0) begin
        grd        = req_rd[g*5 +: 5];
        m_last     = g;
        m_wr_valid = (grd != 0);
        m_wr_rd    = grd;
        m_wr_data  = req_data[g*32 +: 32];
        m_busy[grd] = 1'b0;
      end else begin
        m_wr_valid = 1'b0;
      end
      if (alloc_valid && alloc_rd != 0) m_busy[alloc_rd] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("wr_valid", 32'(wr_valid), 32'(m_wr_valid));
    checkOutput("wr_rd", 32'(wr_rd), 32'(m_wr_rd));
    checkOutput("wr_data", wr_data, m_wr_data);
    checkOutput("busy", busy, m_busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1'b0, 5'd0);
      runCycle();
    end
  endtask

  initial begin
    int seq [6] = '{0, 1, 2, 0, 1, 2};
    m_last = 2; m_busy = '0;
    m_wr_valid = 1'b0; m_wr_rd = '0; m_wr_data = '0;

    // Reset, then release with nothing requested
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1'b0, 5'd0);
      runCycle();
    end
    idle(3);
    checkOutput("idle_busy", busy, 32'h0);

    // All three requesters held: strict rotation 0,1,2,0,1,2
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0);
      #1;
      checkOutput("rr_seq_ready", 32'(req_ready), 32'(1 << seq[i]));
      runCycle();
      checkOutput("rr_seq_wr_rd", 32'(wr_rd), 32'(seq[i] + 1));
    end

    // Allocate x5, wait, then LSU writes it back
    applyStimulus(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1'b1, 5'd5);
    runCycle();
    checkOutput("busy5_set", 32'(busy[5]), 32'd1);
    idle(1);
    checkOutput("busy5_hold", 32'(busy[5]), 32'd1);
    applyStimulus(1'b1, 3'b010, 5'd0, 5'd5, 5'd0, 0, 32'hDEADBEEF, 0, 1'b0, 5'd0);
    runCycle();
    checkOutput("busy5_clear", 32'(busy[5]), 32'd0);
    checkOutput("lsu_wr_valid", 32'(wr_valid), 32'd1);
    checkOutput("lsu_wr_data", wr_data, 32'hDEADBEEF);

    // Allocation and write-back of x7 in the same cycle: set wins
    applyStimulus(1'b1, 3'b001, 5'd7, 5'd0, 5'd0, 32'h77, 0, 0, 1'b1, 5'd7);
    runCycle();
    checkOutput("busy7_set_wins", 32'(busy[7]), 32'd1);
    checkOutput("x7_wr_rd", 32'(wr_rd), 32'd7);

    // CSR writes x0 while x0 is allocated: consumed, no strobe
    applyStimulus(1'b1, 3'b100, 5'd0, 5'd0, 5'd0, 0, 0, 32'hFFFFFFFF, 1'b1, 5'd0);
    runCycle();
    checkOutput("x0_wr_valid", 32'(wr_valid), 32'd0);
    checkOutput("x0_busy0", 32'(busy[0]), 32'd0);

    // Build busy=0xF0, then reset while ALU and LSU request
    for (int r = 4; r < 7; r++) begin
      applyStimulus(1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1'b1, 5'(r));
      runCycle();
    end
    checkOutput("busy_f0", busy, 32'h000000F0);
    applyStimulus(1'b0, 3'b011, 5'd8, 5'd9, 5'd0, 32'hA, 32'hB, 0, 1'b0, 5'd0);
    runCycle();
    checkOutput("rst_busy", busy, 32'h0);
    checkOutput("rst_wr_valid", 32'(wr_valid), 32'd0);
    applyStimulus(1'b1, 3'b011, 5'd8, 5'd9, 5'd0, 32'hA, 32'hB, 0, 1'b0, 5'd0);
    #1;
    checkOutput("post_rst_first", 32'(req_ready), 32'd1);
    runCycle();

    // Random traffic with small register indices to force collisions
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) != 0), 3'($urandom_range(0, 7)),
                    5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)),
                    5'($urandom_range(0, 9)), $urandom, $urandom, $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)));
      runCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
